// File: rtl/match_controller.sv
// Pong game-flow sequencer: start -> serve -> rally -> point -> round/match end.
// Drives the ball control lines and keeps shadow point/round counters to decide round and match completion.
module match_controller #(
    parameter int POINTS_TO_WIN = 9,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int SERVE_DELAY   = 60,
    parameter int POINT_HOLD    = 1_000_000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       start,
    input  logic       tick,
    input  logic       goal_p1,
    input  logic       goal_p2,
    output logic       p1_point,
    output logic       p2_point,
    output logic       ball_reset,
    output logic       ball_run,
    output logic       serve_dir,
    output logic       round_over,
    output logic       match_over,
    output logic       winner,
    output logic [3:0] p1_pts,
    output logic [3:0] p2_pts,
    output logic [1:0] p1_rnd,
    output logic [1:0] p2_rnd,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SERVE_WAIT = 3'd1;
    localparam logic [2:0] S_RALLY      = 3'd2;
    localparam logic [2:0] S_POINT      = 3'd3;
    localparam logic [2:0] S_ROUND_END  = 3'd4;
    localparam logic [2:0] S_MATCH_OVER = 3'd5;

    localparam int SERVE_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam int HOLD_W  = $clog2(POINT_HOLD);

    logic [2:0]         state_q, state_d;
    logic [3:0]         p1_pts_q, p1_pts_d, p2_pts_q, p2_pts_d;
    logic [1:0]         p1_rnd_q, p1_rnd_d, p2_rnd_q, p2_rnd_d;
    logic               serve_dir_q, serve_dir_d;
    logic               winner_q, winner_d;
    logic               scorer_q, scorer_d;   // 0 = P1 scored last, 1 = P2
    logic               p1_point_q, p1_point_d, p2_point_q, p2_point_d;
    logic [SERVE_W-1:0] serve_cnt_q, serve_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               start_meta_q, start_sync_q, start_prev_q;
    logic               start_edge;
    logic [3:0]         scorer_pts;
    logic [1:0]         scorer_rnd_next;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'h3) ? v : v + 2'd1;
    endfunction

    assign start_edge      = start_sync_q & ~start_prev_q;
    assign scorer_pts      = scorer_q ? p2_pts_q : p1_pts_q;
    assign scorer_rnd_next = scorer_q ? sat_inc2(p2_rnd_q) : sat_inc2(p1_rnd_q);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        p1_pts_d    = p1_pts_q;
        p2_pts_d    = p2_pts_q;
        p1_rnd_d    = p1_rnd_q;
        p2_rnd_d    = p2_rnd_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        scorer_d    = scorer_q;
        serve_cnt_d = '0;
        hold_cnt_d  = '0;
        case (state_q)
            S_IDLE, S_MATCH_OVER: begin
                if (start_edge) begin
                    state_d     = S_SERVE_WAIT;
                    p1_pts_d    = '0;
                    p2_pts_d    = '0;
                    p1_rnd_d    = '0;
                    p2_rnd_d    = '0;
                    serve_dir_d = 1'b0;
                end
            end
            S_SERVE_WAIT: begin
                serve_cnt_d = serve_cnt_q;
                if (tick) begin
                    if (serve_cnt_q == SERVE_W'(SERVE_DELAY - 1)) state_d = S_RALLY;
                    else serve_cnt_d = serve_cnt_q + 1'b1;
                end
            end
            S_RALLY: begin
                // P1 takes priority when both goals land in the same cycle.
                if (goal_p1) begin
                    p1_pts_d    = sat_inc4(p1_pts_q);
                    serve_dir_d = 1'b1;
                    scorer_d    = 1'b0;
                    state_d     = S_POINT;
                end else if (goal_p2) begin
                    p2_pts_d    = sat_inc4(p2_pts_q);
                    serve_dir_d = 1'b0;
                    scorer_d    = 1'b1;
                    state_d     = S_POINT;
                end
            end
            S_POINT: begin
                if (hold_cnt_q == HOLD_W'(POINT_HOLD - 1)) begin
                    state_d = (scorer_pts == 4'(POINTS_TO_WIN)) ? S_ROUND_END : S_SERVE_WAIT;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_ROUND_END: begin
                p1_pts_d = '0;
                p2_pts_d = '0;
                if (scorer_q) p2_rnd_d = scorer_rnd_next;
                else          p1_rnd_d = scorer_rnd_next;
                if (scorer_rnd_next == 2'(ROUNDS_TO_WIN)) begin
                    state_d  = S_MATCH_OVER;
                    winner_d = scorer_q;
                end else begin
                    state_d = S_SERVE_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Point pulses are registered so the slow-clock score block sees a glitch-free level.
        p1_point_d = (state_d == S_POINT) && !scorer_d;
        p2_point_d = (state_d == S_POINT) &&  scorer_d;
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= S_IDLE;
            p1_pts_q     <= '0;
            p2_pts_q     <= '0;
            p1_rnd_q     <= '0;
            p2_rnd_q     <= '0;
            serve_dir_q  <= 1'b0;
            winner_q     <= 1'b0;
            scorer_q     <= 1'b0;
            p1_point_q   <= 1'b0;
            p2_point_q   <= 1'b0;
            serve_cnt_q  <= '0;
            hold_cnt_q   <= '0;
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, like real registers.
            state_q      <= state_d;
            p1_pts_q     <= p1_pts_d;
            p2_pts_q     <= p2_pts_d;
            p1_rnd_q     <= p1_rnd_d;
            p2_rnd_q     <= p2_rnd_d;
            serve_dir_q  <= serve_dir_d;
            winner_q     <= winner_d;
            scorer_q     <= scorer_d;
            p1_point_q   <= p1_point_d;
            p2_point_q   <= p2_point_d;
            serve_cnt_q  <= serve_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            start_meta_q <= start;
            start_sync_q <= start_meta_q;
            start_prev_q <= start_sync_q;
        end
    end

    assign p1_point   = p1_point_q;
    assign p2_point   = p2_point_q;
    assign ball_reset = (state_q != S_RALLY);
    assign ball_run   = (state_q == S_RALLY);
    assign serve_dir  = serve_dir_q;
    assign round_over = (state_q == S_ROUND_END);
    assign match_over = (state_q == S_MATCH_OVER);
    assign winner     = winner_q;
    assign p1_pts     = p1_pts_q;
    assign p2_pts     = p2_pts_q;
    assign p1_rnd     = p1_rnd_q;
    assign p2_rnd     = p2_rnd_q;
    assign state      = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed game steps plus random rallies
// checked against a score-keeping model of the game rules.
module tb_match_controller;

    localparam int PTW = 2;
    localparam int RTW = 2;
    localparam int SD  = 3;
    localparam int PH  = 5;

    localparam int ST_IDLE = 0, ST_SERVE = 1, ST_RALLY = 2, ST_POINT = 3, ST_ROUND = 4, ST_MATCH = 5;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic       start    = 1'b0;
    logic       tick     = 1'b0;
    logic       goal_p1  = 1'b0;
    logic       goal_p2  = 1'b0;
    logic       p1_point, p2_point, ball_reset, ball_run, serve_dir;
    logic       round_over, match_over, winner;
    logic [3:0] p1_pts, p2_pts;
    logic [1:0] p1_rnd, p2_rnd;
    logic [2:0] state;

    int vectors     = 0;
    int miscompares = 0;

    // Game model: points and rounds per player, expected serve direction and state.
    int exp_pts[2];
    int exp_rnd[2];
    int exp_dir;
    int exp_winner;
    int exp_state;

    match_controller #(
        .POINTS_TO_WIN(PTW), .ROUNDS_TO_WIN(RTW), .SERVE_DELAY(SD), .POINT_HOLD(PH)
    ) dut (
        .CLOCK_50(CLOCK_50), .Resetn(Resetn), .start(start), .tick(tick),
        .goal_p1(goal_p1), .goal_p2(goal_p2),
        .p1_point(p1_point), .p2_point(p2_point), .ball_reset(ball_reset), .ball_run(ball_run),
        .serve_dir(serve_dir), .round_over(round_over), .match_over(match_over), .winner(winner),
        .p1_pts(p1_pts), .p2_pts(p2_pts), .p1_rnd(p1_rnd), .p2_rnd(p2_rnd), .state(state)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, ".p1_pts"}, 32'(p1_pts), exp_pts[0]);
        check({tag, ".p2_pts"}, 32'(p2_pts), exp_pts[1]);
        check({tag, ".p1_rnd"}, 32'(p1_rnd), exp_rnd[0]);
        check({tag, ".p2_rnd"}, 32'(p2_rnd), exp_rnd[1]);
    endtask

    task automatic clear_model();
        exp_pts[0] = 0; exp_pts[1] = 0;
        exp_rnd[0] = 0; exp_rnd[1] = 0;
        exp_dir    = 0;
    endtask

    task automatic press_start(input int from_state);
        start = 1'b1;
        step();
        step();
        check("start.not_yet", 32'(state), from_state);
        step();
        check("start.seen", 32'(state), ST_SERVE);
        start = 1'b0;
        clear_model();
        exp_state = ST_SERVE;
        check_counters("start");
        check("start.match_over", 32'(match_over), 0);
    endtask

    task automatic serve();
        for (int i = 0; i < SD; i++) begin
            repeat ($urandom_range(0, 2)) begin
                step();
                check("serve.wait", 32'(state), ST_SERVE);
            end
            tick = 1'b1;
            step();
            tick = 1'b0;
            check("serve.tick", 32'(state), (i == SD - 1) ? ST_RALLY : ST_SERVE);
        end
        check("serve.ball_run", 32'(ball_run), 1);
        check("serve.ball_reset", 32'(ball_reset), 0);
        exp_state = ST_RALLY;
    endtask

    // Apply a goal pattern for 'hold' edges starting in RALLY and follow the point to its outcome.
    task automatic score(input logic g1, input logic g2, input int hold);
        int s;
        int held;
        int n;
        int hi;
        int lo;
        s = g1 ? 0 : 1;
        goal_p1 = g1;
        goal_p2 = g2;
        step();
        held = 1;
        exp_pts[s] = exp_pts[s] + 1;
        exp_dir = (s == 0) ? 1 : 0;
        check("goal.state", 32'(state), ST_POINT);
        check_counters("goal");
        check("goal.serve_dir", 32'(serve_dir), exp_dir);
        hi = 0; lo = 0; n = 0;
        while (state == 3'(ST_POINT) && n < 4 * PH) begin
            if ((s == 0) ? p1_point : p2_point) hi++;
            if ((s == 0) ? p2_point : p1_point) lo++;
            if (held >= hold) begin goal_p1 = 1'b0; goal_p2 = 1'b0; end
            step();
            held++;
            n++;
        end
        check("point.pulse_len", hi, PH);
        check("point.other_pulse", lo, 0);
        if (exp_pts[s] == PTW) begin
            check("round.state", 32'(state), ST_ROUND);
            check("round.pulse", 32'(round_over), 1);
            exp_rnd[s] = exp_rnd[s] + 1;
            exp_pts[0] = 0;
            exp_pts[1] = 0;
            exp_state = (exp_rnd[s] == RTW) ? ST_MATCH : ST_SERVE;
            if (exp_state == ST_MATCH) exp_winner = s;
            if (held >= hold) begin goal_p1 = 1'b0; goal_p2 = 1'b0; end
            step();
            held++;
            check("round.pulse_end", 32'(round_over), 0);
            check("round.next", 32'(state), exp_state);
            check_counters("round");
            if (exp_state == ST_MATCH) begin
                check("match.level", 32'(match_over), 1);
                check("match.winner", 32'(winner), exp_winner);
            end
        end else begin
            exp_state = ST_SERVE;
            check("point.next", 32'(state), ST_SERVE);
        end
        while (held < hold) begin
            step();
            held++;
        end
        goal_p1 = 1'b0;
        goal_p2 = 1'b0;
        check("hold.state", 32'(state), exp_state);
        check_counters("hold");
    endtask

    initial begin
        int guard;
        clear_model();
        exp_winner = 0;
        exp_state  = ST_IDLE;

        // Reset values
        repeat (2) step();
        check("rst.state", 32'(state), ST_IDLE);
        check("rst.ball_reset", 32'(ball_reset), 1);
        check("rst.ball_run", 32'(ball_run), 0);
        check("rst.serve_dir", 32'(serve_dir), 0);
        check("rst.winner", 32'(winner), 0);
        check("rst.pulses", 32'({p1_point, p2_point, round_over, match_over}), 0);
        check_counters("rst");
        #5 Resetn = 1'b1;

        // Goals in IDLE are ignored
        goal_p1 = 1'b1; goal_p2 = 1'b1;
        repeat (4) step();
        goal_p1 = 1'b0; goal_p2 = 1'b0;
        check("idle.state", 32'(state), ST_IDLE);
        check_counters("idle");

        // Start, serve, P2 goal held 10 cycles
        press_start(ST_IDLE);
        serve();
        score(1'b0, 1'b1, 10);

        // Simultaneous goals: P1 wins the tie
        serve();
        score(1'b1, 1'b1, 1);

        // P1 closes round 1, then wins round 2 and the match
        serve();
        score(1'b1, 1'b0, 2);
        serve();
        score(1'b1, 1'b0, 3);
        serve();
        score(1'b1, 1'b0, 1);
        check("match.p1_wins", 32'(winner), 0);

        // Goals and ticks while the match is over change nothing
        for (int i = 0; i < 8; i++) begin
            goal_p1 = 1'($urandom_range(0, 1));
            goal_p2 = 1'($urandom_range(0, 1));
            tick    = 1'($urandom_range(0, 1));
            step();
        end
        goal_p1 = 1'b0; goal_p2 = 1'b0; tick = 1'b0;
        check("frozen.state", 32'(state), ST_MATCH);
        check("frozen.match_over", 32'(match_over), 1);
        check_counters("frozen");

        // Restart and play a random match to completion
        press_start(ST_MATCH);
        guard = 0;
        while (exp_state != ST_MATCH && guard < 40) begin
            int r;
            r = $urandom_range(0, 2);
            serve();
            score(r != 1, r != 0, $urandom_range(1, 8));
            guard++;
        end
        check("random.match_over", 32'(match_over), 1);
        check("random.winner", 32'(winner), exp_winner);

        // Reset during the second cycle of a point hold
        press_start(ST_MATCH);
        serve();
        goal_p1 = 1'b1;
        step();
        goal_p1 = 1'b0;
        step();
        check("midrst.pulse_before", 32'(p1_point), 1);
        #3 Resetn = 1'b0;
        #1;
        clear_model();
        check("midrst.pulse", 32'(p1_point), 0);
        check("midrst.state", 32'(state), ST_IDLE);
        check("midrst.ball_reset", 32'(ball_reset), 1);
        check("midrst.ball_run", 32'(ball_run), 0);
        check_counters("midrst");
        #5 Resetn = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
